aclk_key_entry: RTL and testbench

Keypad front end for the alarm clock. It debounces raw keypad codes and shifts digits into a 4-digit key buffer. It tracks the entry sequence, validates the entered time, and issues load strobes for the time and alarm registers. It drives the `key_buffer_*`, `show_new_time` and `show_a` inputs of `aclk_lcd_display`, and so is the writer side of that display interface.

---
 rtl/aclk_key_entry.sv | 249 ++++++++++++++++++++++++
 tb/tb_aclk_key_entry.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aclk_key_entry.sv
// aclk_key_entry - keypad front end for the alarm clock.
//
// Debounces raw keypad codes, shifts digits into a 4-digit key buffer,
// validates the entered time and issues one-cycle load strobes for the
// current-time and alarm registers. Drives the key buffer, show_new_time
// and show_a inputs of the LCD display block.
//
// Parameters:
//   DEBOUNCE_CYC  consecutive stable samples to accept a press/release (2..255)
//   TIMEOUT_S     one_second ticks without a key before an entry aborts (1..15)
//
// Ports:
//   clock, reset (async, active-high)
//   key[3:0], key_valid    raw keypad code and held level
//   one_second             one-cycle tick per second
//   key_buffer_*[3:0]      entered digits (ms_hr, ls_hr, ms_min, ls_min)
//   show_new_time          entry in progress
//   show_a                 ALARM held with no entry in progress
//   load_new_c/load_new_a  commit strobes for current/alarm time
//   entry_error            commit rejected, buffer is not a valid time
//
// Configuration macro: ACLK_KEY_ENTRY_TIMEOUT_EN builds the entry timeout;
// without it one_second is ignored and an entry lasts until TIME or ALARM.

module aclk_key_entry #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int TIMEOUT_S    = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] key,
   input  logic       key_valid,
   input  logic       one_second,
   output logic [3:0] key_buffer_ms_hr,
   output logic [3:0] key_buffer_ls_hr,
   output logic [3:0] key_buffer_ms_min,
   output logic [3:0] key_buffer_ls_min,
   output logic       show_new_time,
   output logic       show_a,
   output logic       load_new_c,
   output logic       load_new_a,
   output logic       entry_error
);

   localparam logic [3:0] KEY_ALARM = 4'd10;
   localparam logic [3:0] KEY_TIME  = 4'd11;
   localparam logic [7:0] DEB_MAX   = 8'(DEBOUNCE_CYC);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY      = 2'd1,
      SHOW_ALARM = 2'd2
   } state_t;

   // A buffer is a valid time when it reads 00:00 .. 23:59.
   function automatic logic valid_time(input logic [3:0] h1, input logic [3:0] h0,
                                       input logic [3:0] m1, input logic [3:0] m0);
      logic hr_ok;
      if (h1 > 4'd2) begin
         hr_ok = 1'b0;
      end else if (h1 == 4'd2) begin
         hr_ok = (h0 <= 4'd3);
      end else begin
         hr_ok = (h0 <= 4'd9);
      end
      return hr_ok && (m1 <= 4'd5) && (m0 <= 4'd9);
   endfunction

   logic [3:0] key_smp_r;
   logic       valid_smp_r;
   logic [3:0] trk_key_r;
   logic       trk_valid_r;
   logic [7:0] stab_cnt_r;
   logic       armed_r;
   logic       kpress_r;
   logic [3:0] kcode_r;
   logic       krelease_r;
   logic       same_s;

   state_t     state_r, state_s;
   logic [3:0] h1_s, h0_s, m1_s, m0_s;
   logic       load_c_s, load_a_s, err_s;
   logic       key_acc_s, is_digit_s, timeout_s;

   // Input sample register: the raw keypad lines are registered once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         key_smp_r   <= 4'd0;
         valid_smp_r <= 1'b0;
      end else begin
         key_smp_r   <= key;
         valid_smp_r <= key_valid;
      end
   end

   // The tracked condition is "released" or "held with this code"; any
   // change of condition restarts the stability count at one sample.
   assign same_s = (valid_smp_r == trk_valid_r) &&
                   (!valid_smp_r || (key_smp_r == trk_key_r));

   // Debounce: a press fires once, then is disarmed until a debounced release.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         trk_key_r   <= 4'd0;
         trk_valid_r <= 1'b0;
         stab_cnt_r  <= 8'd0;
         armed_r     <= 1'b1;
         kpress_r    <= 1'b0;
         kcode_r     <= 4'd0;
         krelease_r  <= 1'b0;
      end else begin
         kpress_r   <= 1'b0;
         krelease_r <= 1'b0;
         if (!same_s) begin
            trk_key_r   <= key_smp_r;
            trk_valid_r <= valid_smp_r;
            stab_cnt_r  <= 8'd1;
         end else if (stab_cnt_r < DEB_MAX) begin
            stab_cnt_r <= stab_cnt_r + 8'd1;
            if (stab_cnt_r == DEB_MAX - 8'd1) begin
               if (valid_smp_r) begin
                  if (armed_r) begin
                     kpress_r <= 1'b1;
                     kcode_r  <= key_smp_r;
                     armed_r  <= 1'b0;
                  end
               end else begin
                  armed_r    <= 1'b1;
                  krelease_r <= 1'b1;
               end
            end
         end
      end
   end

   // Codes 12..15 are accepted by the debouncer but never act as keys.
   assign key_acc_s  = kpress_r && (kcode_r <= KEY_TIME);
   assign is_digit_s = (kcode_r <= 4'd9);

`ifdef ACLK_KEY_ENTRY_TIMEOUT_EN
   logic [3:0] tmo_cnt_r;

   assign timeout_s = (state_r == ENTRY) && one_second &&
                      (tmo_cnt_r == 4'(TIMEOUT_S - 1));

   // Timeout counter: idle at zero outside ENTRY, cleared by any real key.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tmo_cnt_r <= 4'd0;
      end else if ((state_r != ENTRY) || key_acc_s || timeout_s) begin
         tmo_cnt_r <= 4'd0;
      end else if (one_second) begin
         tmo_cnt_r <= tmo_cnt_r + 4'd1;
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end
`else
   logic unused_one_second;
   assign unused_one_second = one_second;
   assign timeout_s         = 1'b0;
`endif

   // Next-state, buffer and strobe decode; an accepted key beats the timeout.
   always_comb begin
      state_s  = state_r;
      h1_s     = key_buffer_ms_hr;
      h0_s     = key_buffer_ls_hr;
      m1_s     = key_buffer_ms_min;
      m0_s     = key_buffer_ls_min;
      load_c_s = 1'b0;
      load_a_s = 1'b0;
      err_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (key_acc_s && is_digit_s) begin
               h1_s    = 4'd0;
               h0_s    = 4'd0;
               m1_s    = 4'd0;
               m0_s    = kcode_r;
               state_s = ENTRY;
            end else if (key_acc_s && (kcode_r == KEY_ALARM)) begin
               state_s = SHOW_ALARM;
            end else begin
               state_s = IDLE;
            end
         end
         ENTRY: begin
            if (key_acc_s && is_digit_s) begin
               h1_s = key_buffer_ls_hr;
               h0_s = key_buffer_ms_min;
               m1_s = key_buffer_ls_min;
               m0_s = kcode_r;
            end else if (key_acc_s) begin
               state_s = IDLE;
               if (valid_time(key_buffer_ms_hr, key_buffer_ls_hr,
                              key_buffer_ms_min, key_buffer_ls_min)) begin
                  load_c_s = (kcode_r == KEY_TIME);
                  load_a_s = (kcode_r == KEY_ALARM);
               end else begin
                  err_s = 1'b1;
               end
            end else if (timeout_s) begin
               state_s = IDLE;
            end else begin
               state_s = ENTRY;
            end
         end
         SHOW_ALARM: begin
            if (krelease_r) begin
               state_s = IDLE;
            end else begin
               state_s = SHOW_ALARM;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers: every output is a flop fed from next state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r           <= IDLE;
         key_buffer_ms_hr  <= 4'd0;
         key_buffer_ls_hr  <= 4'd0;
         key_buffer_ms_min <= 4'd0;
         key_buffer_ls_min <= 4'd0;
         show_new_time     <= 1'b0;
         show_a            <= 1'b0;
         load_new_c        <= 1'b0;
         load_new_a        <= 1'b0;
         entry_error       <= 1'b0;
      end else begin
         state_r           <= state_s;
         key_buffer_ms_hr  <= h1_s;
         key_buffer_ls_hr  <= h0_s;
         key_buffer_ms_min <= m1_s;
         key_buffer_ls_min <= m0_s;
         show_new_time     <= (state_s == ENTRY);
         show_a            <= (state_s == SHOW_ALARM);
         load_new_c        <= load_c_s;
         load_new_a        <= load_a_s;
         entry_error       <= err_s;
      end
   end

endmodule

// File: tb/tb_aclk_key_entry.sv
// Testbench for aclk_key_entry: table of key presses with expected outputs,
// hand-written multi-cycle sequences (bounce, timeout, SHOW_ALARM, reset)
// and random key sequences checked against a digit-queue model.

module tb_aclk_key_entry;

   localparam int DC = 4;
   localparam int TS = 10;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] key = 4'd0;
   logic       key_valid = 1'b0;
   logic       one_second = 1'b0;
   logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
   logic       show_new_time, show_a, load_new_c, load_new_a, entry_error;

   logic [15:0] bufv;
   logic [4:0]  flags;
   assign bufv  = {ms_hr, ls_hr, ms_min, ls_min};
   assign flags = {show_new_time, show_a, load_new_c, load_new_a, entry_error};

   aclk_key_entry #(.DEBOUNCE_CYC(DC), .TIMEOUT_S(TS)) dut (
      .clock(clock),
      .reset(reset),
      .key(key),
      .key_valid(key_valid),
      .one_second(one_second),
      .key_buffer_ms_hr(ms_hr),
      .key_buffer_ls_hr(ls_hr),
      .key_buffer_ms_min(ms_min),
      .key_buffer_ls_min(ls_min),
      .show_new_time(show_new_time),
      .show_a(show_a),
      .load_new_c(load_new_c),
      .load_new_a(load_new_a),
      .entry_error(entry_error)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;
   logic [1:0] last_f = 2'b00;   // {show_new_time, show_a} before the next press

   typedef struct {
      logic [3:0]  code;
      logic [15:0] exp_buf;
      logic [4:0]  exp_flags;   // {snt, show_a, load_c, load_a, err}
   } vec_t;

   vec_t vecs[23];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Clean press: hold, check latency edge, strobe width, then debounced release.
   task automatic press_chk(input string nm, input logic [3:0] code, input int extra,
                            input logic [15:0] eb, input logic [4:0] ef);
      logic [4:0] steady;
      steady = {ef[4:3], 3'b000};
      @(negedge clock);
      key = code;
      key_valid = 1'b1;
      repeat (DC + 1) @(posedge clock);
      #1;
      chk({nm, " pre-latency"}, flags, {last_f, 3'b000});
      @(posedge clock);
      #1;
      chk({nm, " buffer"}, bufv, eb);
      chk({nm, " flags"}, flags, ef);
      @(posedge clock);
      #1;
      chk({nm, " strobe width"}, flags, steady);
      repeat (extra) @(posedge clock);
      @(negedge clock);
      key_valid = 1'b0;
      repeat (DC + 1) @(posedge clock);
      #1;
      chk({nm, " pre-release"}, flags, steady);
      @(posedge clock);
      #1;
      chk({nm, " release"}, flags, {ef[4], 4'b0000});
      last_f = {ef[4], 1'b0};
   endtask

   initial begin
      int q[$];
      int mode;
      int hh, mm, r;
      logic [3:0]  code;
      logic [4:0]  ef;
      logic [15:0] eb;

      // Press table: commit time, commit alarm valid/invalid, overflow, ignored codes.
      vecs[0]  = '{4'd1,  16'h0001, 5'b10000};
      vecs[1]  = '{4'd8,  16'h0018, 5'b10000};
      vecs[2]  = '{4'd0,  16'h0180, 5'b10000};
      vecs[3]  = '{4'd3,  16'h1803, 5'b10000};
      vecs[4]  = '{4'd11, 16'h1803, 5'b00100};
      vecs[5]  = '{4'd2,  16'h0002, 5'b10000};
      vecs[6]  = '{4'd3,  16'h0023, 5'b10000};
      vecs[7]  = '{4'd5,  16'h0235, 5'b10000};
      vecs[8]  = '{4'd9,  16'h2359, 5'b10000};
      vecs[9]  = '{4'd10, 16'h2359, 5'b00010};
      vecs[10] = '{4'd2,  16'h0002, 5'b10000};
      vecs[11] = '{4'd4,  16'h0024, 5'b10000};
      vecs[12] = '{4'd8,  16'h0248, 5'b10000};
      vecs[13] = '{4'd7,  16'h2487, 5'b10000};
      vecs[14] = '{4'd10, 16'h2487, 5'b00001};
      vecs[15] = '{4'd1,  16'h0001, 5'b10000};
      vecs[16] = '{4'd2,  16'h0012, 5'b10000};
      vecs[17] = '{4'd3,  16'h0123, 5'b10000};
      vecs[18] = '{4'd4,  16'h1234, 5'b10000};
      vecs[19] = '{4'd5,  16'h2345, 5'b10000};
      vecs[20] = '{4'd11, 16'h2345, 5'b00100};
      vecs[21] = '{4'd11, 16'h2345, 5'b00000};
      vecs[22] = '{4'd13, 16'h2345, 5'b00000};

      // Reset state.
      #12;
      chk("reset buffer", bufv, 16'h0000);
      chk("reset flags", flags, 5'b00000);
      @(negedge clock);
      reset = 1'b0;
      repeat (DC + 3) @(posedge clock);
      #1;
      chk("post-reset idle", {bufv, flags}, 21'h0);

      for (int i = 0; i < 23; i++) begin
         press_chk($sformatf("vec%0d", i), vecs[i].code, 2, vecs[i].exp_buf, vecs[i].exp_flags);
      end

      // Glitch: key_valid high for only three samples.
      @(negedge clock);
      key = 4'd5;
      key_valid = 1'b1;
      repeat (3) @(negedge clock);
      key_valid = 1'b0;
      repeat (DC + 4) @(posedge clock);
      #1;
      chk("glitch buffer", bufv, 16'h2345);
      chk("glitch flags", flags, 5'b00000);

      // Bounce before acceptance: one digit.
      @(negedge clock);
      key_valid = 1'b1;
      repeat (3) @(negedge clock);
      key_valid = 1'b0;
      repeat (2) @(negedge clock);
      key_valid = 1'b1;
      repeat (10) @(negedge clock);
      key_valid = 1'b0;
      repeat (DC + 3) @(negedge clock);
      chk("bounce-a buffer", bufv, 16'h0005);
      chk("bounce-a flags", flags, 5'b10000);

      // Dropout after acceptance: still only one digit.
      key_valid = 1'b1;
      repeat (8) @(negedge clock);
      key_valid = 1'b0;
      repeat (2) @(negedge clock);
      key_valid = 1'b1;
      repeat (8) @(negedge clock);
      key_valid = 1'b0;
      repeat (DC + 3) @(negedge clock);
      chk("bounce-b buffer", bufv, 16'h0055);
      chk("bounce-b flags", flags, 5'b10000);
      last_f = 2'b10;
      press_chk("bounce commit", 4'd11, 1, 16'h0055, 5'b00100);

      // Timeout: digit then ten one_second ticks.
      press_chk("timeout digit", 4'd5, 0, 16'h0005, 5'b10000);
      for (int t = 1; t <= TS; t++) begin
         @(negedge clock);
         one_second = 1'b1;
         @(posedge clock);
         #1;
`ifdef ACLK_KEY_ENTRY_TIMEOUT_EN
         chk($sformatf("tick%0d flags", t), flags, (t < TS) ? 5'b10000 : 5'b00000);
`else
         chk($sformatf("tick%0d flags", t), flags, 5'b10000);
`endif
         @(negedge clock);
         one_second = 1'b0;
         repeat (2) @(posedge clock);
      end
      #1;
      chk("timeout buffer", bufv, 16'h0005);
`ifdef ACLK_KEY_ENTRY_TIMEOUT_EN
      last_f = 2'b00;
      press_chk("after timeout time", 4'd11, 0, 16'h0005, 5'b00000);
`else
      press_chk("persist commit", 4'd11, 0, 16'h0005, 5'b00100);
`endif

      // ALARM held ~20 cycles in IDLE.
      press_chk("alarm hold", 4'd10, 13, 16'h0005, 5'b01000);

      // Reset mid-entry and mid-debounce.
      press_chk("reset digit", 4'd7, 0, 16'h0007, 5'b10000);
      @(negedge clock);
      key = 4'd8;
      key_valid = 1'b1;
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset buffer", bufv, 16'h0000);
      chk("async reset flags", flags, 5'b00000);
      @(negedge clock);
      reset = 1'b0;
      key_valid = 1'b0;
      repeat (DC + 8) @(posedge clock);
      #1;
      chk("after reset", {bufv, flags}, 21'h0);
      last_f = 2'b00;

      // Random presses against a digit-queue model.
      q = {0, 0, 0, 0};
      mode = 0;
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 99);
         if (r < 60)      code = 4'($urandom_range(0, 9));
         else if (r < 75) code = 4'd11;
         else if (r < 87) code = 4'd10;
         else             code = 4'($urandom_range(12, 15));
         ef = 5'b00000;
         if (mode == 0) begin
            if (code <= 4'd9) begin
               q = {0, 0, 0, int'(code)};
               mode = 1;
            end else if (code == 4'd10) begin
               mode = 2;
            end
         end else if (mode == 1) begin
            if (code <= 4'd9) begin
               q.push_back(int'(code));
               void'(q.pop_front());
            end else if (code <= 4'd11) begin
               hh = q[0] * 10 + q[1];
               mm = q[2] * 10 + q[3];
               if (hh < 24 && mm < 60) ef[(code == 4'd11) ? 2 : 1] = 1'b1;
               else                    ef[0] = 1'b1;
               mode = 0;
            end
         end
         ef[4] = (mode == 1);
         ef[3] = (mode == 2);
         eb = {4'(q[0]), 4'(q[1]), 4'(q[2]), 4'(q[3])};
         press_chk($sformatf("rand%0d", n), code, $urandom_range(0, 5), eb, ef);
         if (mode == 2) mode = 0;
         repeat ($urandom_range(0, 3)) @(posedge clock);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
